// File: rtl/piso_reg.sv
//==============================================================================
// Module   : piso_reg
// Purpose  : Parallel-in / serial-out shift register. Accepts a DATA_WIDTH word
//            through a valid/ready load handshake. Shifts it out one bit per
//            clock on serial_out_o, qualified by we_o. The bit order
//            (MSB- or LSB-first) is chosen per word. Back-to-back words
//            stream without gaps when a new word is accepted in the cycle
//            that carries the previous frame's last bit.
// Ports    : clk_i          - clock, rising edge
//            arst_n_i       - asynchronous active-low reset
//            parallel_in_i  - word to serialize (sampled on acceptance)
//            load_valid_i   - parallel_in_i / shift_dir_i are valid
//            load_ready_o   - block can accept a word this cycle
//            shift_dir_i    - 1 = MSB first, 0 = LSB first
//            serial_out_o   - current serial bit (0 when we_o = 0)
//            we_o           - serial_out_o carries a valid frame bit
//            last_o         - high with the final bit of a frame
// Options  : PISO_REG_PARITY_EN - when defined, appends one even-parity bit
//            (XOR of the captured word) after the data bits.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module piso_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic [DATA_WIDTH-1:0] parallel_in_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic                  shift_dir_i,
  output logic                  serial_out_o,
  output logic                  we_o,
  output logic                  last_o
);

`ifdef PISO_REG_PARITY_EN
  localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
  localparam int FRAME_LEN = DATA_WIDTH;
`endif
  localparam int              CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  dir_q,   dir_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
`ifdef PISO_REG_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic                  accept;
  logic                  is_last;
  logic                  data_bit;
  logic [DATA_WIDTH-1:0] shifted;

  // Outputs derive only from registered state; no input reaches them.
  assign is_last      = (state_q == ST_SHIFT) && (cnt_q == '0);
  assign load_ready_o = (state_q == ST_IDLE) || is_last;
  assign accept       = load_valid_i && load_ready_o;

  assign shifted = dir_q ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                         : {1'b0, shift_q[DATA_WIDTH-1:1]};

`ifdef PISO_REG_PARITY_EN
  // The count reaches zero only on the parity slot; data bits use 1..W.
  assign data_bit = (cnt_q == '0) ? parity_q
                                  : (dir_q ? shift_q[DATA_WIDTH-1] : shift_q[0]);
`else
  assign data_bit = dir_q ? shift_q[DATA_WIDTH-1] : shift_q[0];
`endif

  assign we_o         = (state_q == ST_SHIFT);
  assign serial_out_o = we_o && data_bit;
  assign last_o       = is_last;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
`ifdef PISO_REG_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SHIFT;
          shift_d  = parallel_in_i;
          dir_d    = shift_dir_i;
          cnt_d    = CNT_LOAD;
`ifdef PISO_REG_PARITY_EN
          parity_d = ^parallel_in_i;
`endif
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          if (accept) begin
            // Gapless hand-over: the next word starts in the following cycle.
            shift_d  = parallel_in_i;
            dir_d    = shift_dir_i;
            cnt_d    = CNT_LOAD;
`ifdef PISO_REG_PARITY_EN
            parity_d = ^parallel_in_i;
`endif
          end else begin
            state_d = ST_IDLE;
            shift_d = shifted;
          end
        end else begin
          shift_d = shifted;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef PISO_REG_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
`ifdef PISO_REG_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_piso_reg.sv
//==============================================================================
// Module   : tb_piso_reg
// Purpose  : Self-checking bench for piso_reg (DATA_WIDTH = 8). Stimulus
//            pushes each accepted word's expected bit stream into a
//            scoreboard queue; a monitor pops one entry per we cycle.
// Options  : PISO_REG_PARITY_EN - adds the expected parity bit per frame.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_piso_reg;

  localparam int DW = 8;
`ifdef PISO_REG_PARITY_EN
  localparam int FL = DW + 1;
`else
  localparam int FL = DW;
`endif

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [DW-1:0] parallel_in = '0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic          shift_dir = 1'b0;
  logic          serial_out;
  logic          we;
  logic          last;

  piso_reg #(.DATA_WIDTH(DW)) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .parallel_in_i(parallel_in),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .shift_dir_i  (shift_dir),
    .serial_out_o (serial_out),
    .we_o         (we),
    .last_o       (last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   remaining = 0;   // frame bits the model still expects on the wire
  logic started = 1'b0;

  // Expected bit stream of one frame, built from the word and bit order.
  task automatic push_frame(input logic [DW-1:0] w, input logic d);
    exp_t e;
    for (int i = 0; i < DW; i++) begin
      e.b = d ? w[DW-1-i] : w[i];
      e.l = (i == FL - 1);
      sb.push_back(e);
    end
`ifdef PISO_REG_PARITY_EN
    e.b = ^w;
    e.l = 1'b1;
    sb.push_back(e);
`endif
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] w, input logic d,
                       output logic acc);
    logic exp_ready;
    @(negedge clk);
    load_valid  = v;
    parallel_in = w;
    shift_dir   = d;
    #1;
    exp_ready = (remaining <= 1);
    total++;
    if (load_ready !== exp_ready) begin
      bad++;
      $display("FAIL load_ready t=%0t: got %b want %b", $time, load_ready, exp_ready);
    end
    @(posedge clk);
    acc = v && exp_ready;
    if (remaining > 0) remaining--;
    if (acc) begin
      push_frame(w, d);
      remaining = FL;
    end
  endtask

  task automatic send(input logic [DW-1:0] w, input logic d);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 64) begin
      cycle(1'b1, w, d, acc);
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: word %h not accepted within %0d cycles", w, n);
    end
  endtask

  // Idle cycles drive random data/direction to show they are ignored.
  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, DW'($urandom), 1'($urandom), acc);
  endtask

  task automatic reset_mid_frame();
    @(negedge clk);
    load_valid = 1'b0;
    #2 arst_n = 1'b0;
    #1;
    total++;
    if (serial_out !== 1'b0 || we !== 1'b0 || last !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: got so=%b we=%b last=%b rdy=%b want 0 0 0 1",
               serial_out, we, last, load_ready);
    end
    sb.delete();
    remaining = 0;
    #1 arst_n = 1'b1;
    @(posedge clk);
  endtask

  // Monitor: one scoreboard entry per we cycle, idle checks otherwise.
  exp_t m;
  initial begin
    wait (started);
    forever begin
      @(posedge clk);
      #1;
      if (arst_n) begin
        total++;
        if (we === 1'b1) begin
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_bit t=%0t: got we=1 so=%b want we=0", $time, serial_out);
          end else begin
            m = sb.pop_front();
            if (serial_out !== m.b || last !== m.l) begin
              bad++;
              $display("FAIL frame_bit t=%0t: got so=%b last=%b want so=%b last=%b",
                       $time, serial_out, last, m.b, m.l);
            end
          end
        end else if (we !== 1'b0 || serial_out !== 1'b0 || last !== 1'b0 || sb.size() != 0) begin
          bad++;
          $display("FAIL idle_out t=%0t: got we=%b so=%b last=%b pending=%0d want 0 0 0 0",
                   $time, we, serial_out, last, sb.size());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #3;
    total++;
    if (serial_out !== 1'b0 || we !== 1'b0 || last !== 1'b0 || load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got so=%b we=%b last=%b rdy=%b want 0 0 0 1",
               serial_out, we, last, load_ready);
    end
    @(negedge clk);
    #1 arst_n = 1'b1;
    started = 1'b1;

    idle(2);
    send(8'h1E, 1'b1);          // 0,0,0,1,1,1,1,0
    idle(FL + 2);
    send(8'h1E, 1'b0);          // 0,1,1,1,1,0,0,0 with inputs churning
    idle(FL + 2);
    send(8'h96, 1'b1);          // back-to-back, no bubble
    send(8'h01, 1'b0);
    idle(FL + 2);
    send(8'hFF, 1'b1);
    idle(3);
    reset_mid_frame();          // in the 4th bit of 0xFF
    send(8'h55, 1'b1);
    idle(FL + 2);
    send(8'h07, 1'b1);
    idle(FL + 2);

    repeat (60) begin
      send(DW'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, FL + 2));
    end
    idle(FL + 3);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending bits want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
